// File: rtl/mcc_subtractor_seq.sv
// mcc_subtractor_seq: chunk-serial subtractor, diff = a - b - bin over N bits,
// CHUNK bits per clock, valid/ready on both sides, one operation in flight.
// Optional macro MCC_SUB_OVF_EN adds the signed-overflow output ovf.
module mcc_subtractor_seq #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef MCC_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NCH = N / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad_params
            $error("mcc_subtractor_seq: N must be a multiple of CHUNK and 1 <= CHUNK <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic            carry;
    logic [CHUNK:0]  sum;
    logic [N+CHUNK-1:0] diff_cat;
`ifdef MCC_SUB_OVF_EN
    logic            sign_a;
    logic            sign_b;
`endif

    // Chunk adder: the low chunk of the shifting operands plus ~b and the carry.
    // Operands shift right each BUSY cycle and each result chunk enters diff
    // from the top, so after N/CHUNK steps chunk k sits at bits k*CHUNK.
    always_comb begin
        sum      = {1'b0, a_r[CHUNK-1:0]} + {1'b0, ~b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        diff_cat = {sum[CHUNK-1:0], diff};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake/result outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bout      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                bout      = ~carry;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at accept and one chunk of the borrow chain per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            diff  <= '0;
`ifdef MCC_SUB_OVF_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= ~bin;
                        cnt   <= '0;
`ifdef MCC_SUB_OVF_EN
                        sign_a <= a[N-1];
                        sign_b <= b[N-1];
`endif
                    end
                end
                BUSY: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= sum[CHUNK];
                    diff  <= diff_cat[N+CHUNK-1:CHUNK];
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef MCC_SUB_OVF_EN
    // Signed overflow from the captured sign bits and the finished result.
    always_comb begin
        ovf = (state == DONE) && (sign_a != sign_b) && (diff[N-1] != sign_a);
    end
`endif

endmodule

// File: tb/tb_mcc_subtractor_seq.sv
// tb_mcc_subtractor_seq: scoreboard bench for mcc_subtractor_seq with N=8 and
// CHUNK = 4, 1, 2, 8 instantiated side by side.
module tb_mcc_subtractor_seq;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [4];
    logic       irdy [4];
    logic [7:0] a_s  [4];
    logic [7:0] b_s  [4];
    logic       bin_s[4];
    logic       ovld [4];
    logic       ordy [4];
    logic [7:0] dif  [4];
    logic       bo   [4];
`ifdef MCC_SUB_OVF_EN
    logic       ovf_s[4];
`endif

    int   LAT[4] = '{2, 8, 4, 1};
    int   rmode[4];
    bit   seen[4];
    exp_t sbq[4][$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        mcc_subtractor_seq #(.N(8), .CHUNK(CH)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (irdy[g]),
            .a        (a_s[g]),
            .b        (b_s[g]),
            .bin      (bin_s[g]),
            .out_valid(ovld[g]),
            .out_ready(ordy[g]),
            .diff     (dif[g]),
            .bout     (bo[g])
`ifdef MCC_SUB_OVF_EN
            ,
            .ovf      (ovf_s[g])
`endif
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        exp_t e;
        int   r;
        int   sr;
        r  = int'(av) - int'(bv) - int'(bi);
        sr = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.bo  = (r < 0);
        e.d   = 8'((r < 0) ? r + 256 : r);
        e.ov  = (sr < -128) || (sr > 127);
        e.acc = 0;
        return e;
    endfunction

    // Entered and left at posedge+1.
    task automatic issue(input int i, input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int   n;
        exp_t e;
        iv[i] = 1'b1;
        a_s[i] = av;
        b_s[i] = bv;
        bin_s[i] = bi;
        n = 0;
        while (!irdy[i] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!irdy[i]) begin
            total++;
            $display("FAIL accept_timeout[%0d]: got in_ready=0 expected 1", i);
            iv[i] = 1'b0;
            return;
        end
        e = model(av, bv, bi);
        e.acc = cyc + 1;
        sbq[i].push_back(e);
        @(posedge clk); #1;
        iv[i] = 1'b0;
        a_s[i] = 8'($urandom);
        b_s[i] = 8'($urandom);
        bin_s[i] = 1'($urandom);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (sbq[i].size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq[i].size() != 0) begin
            total++;
            $display("FAIL drain_timeout[%0d]: got %0d pending expected 0", i, sbq[i].size());
        end
    endtask

    task automatic run_rand(input int i, input int count);
        for (int k = 0; k < count; k++) begin
            issue(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain(i);
    endtask

    // Consumer: always ready, random backpressure, or left to the directed code.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (rmode[i] == 0) ordy[i] = 1'b1;
                else if (rmode[i] == 1) ordy[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compare the head of each scoreboard while out_valid is high.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rst_n && ovld[i]) begin
                if (sbq[i].size() == 0) begin
                    total++;
                    $display("FAIL spurious_out_valid[%0d]: got out_valid=1 expected 0", i);
                end else begin
                    e = sbq[i][0];
                    if (!seen[i]) chk($sformatf("latency[%0d]", i), cyc - e.acc, LAT[i]);
                    chk($sformatf("diff[%0d]", i), dif[i], e.d);
                    chk($sformatf("bout[%0d]", i), bo[i], e.bo);
`ifdef MCC_SUB_OVF_EN
                    chk($sformatf("ovf[%0d]", i), ovf_s[i], e.ov);
`endif
                    chk($sformatf("in_ready_while_done[%0d]", i), irdy[i], 0);
                    seen[i] = 1'b1;
                    if (ordy[i]) begin
                        void'(sbq[i].pop_front());
                        seen[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; bin_s[i] = 1'b0;
            ordy[i] = 1'b0; rmode[i] = 0; seen[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), irdy[i], 1);
            chk($sformatf("rst_out_valid[%0d]", i), ovld[i], 0);
            chk($sformatf("rst_diff[%0d]", i), dif[i], 0);
            chk($sformatf("rst_bout[%0d]", i), bo[i], 0);
        end

        issue(0, 8'h5A, 8'h3C, 1'b0);
        issue(0, 8'h00, 8'h01, 1'b0);
        issue(0, 8'hFF, 8'hFF, 1'b1);
        issue(0, 8'h00, 8'h00, 1'b1);
`ifdef MCC_SUB_OVF_EN
        issue(0, 8'h80, 8'h01, 1'b0);
        issue(0, 8'h7F, 8'hFF, 1'b0);
`endif
        drain(0);

        // Backpressure: result held 5 cycles while a new request is offered.
        rmode[0] = 2;
        ordy[0] = 1'b0;
        issue(0, 8'h33, 8'h11, 1'b0);
        n = 0;
        while (!ovld[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid", ovld[0], 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            iv[0] = 1'b1; a_s[0] = 8'h10; b_s[0] = 8'h00; bin_s[0] = 1'b0;
            chk("bp_in_ready_low", irdy[0], 0);
            chk("bp_out_valid_held", ovld[0], 1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after_hs", irdy[0], 1);
        chk("bp_out_valid_after_hs", ovld[0], 0);
        ordy[0] = 1'b0;
        rmode[0] = 0;
        drain(0);

        // Reset one cycle into BUSY discards the operation.
        issue(0, 8'h77, 8'h11, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", irdy[0], 1);
        chk("midrst_out_valid", ovld[0], 0);
        chk("midrst_diff", dif[0], 0);
        chk("midrst_bout", bo[0], 0);
        sbq[0].delete();
        seen[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(0, 8'h09, 8'h04, 1'b0);
        drain(0);

        // Random sweep across all chunk widths with random backpressure.
        for (int i = 0; i < 4; i++) rmode[i] = 1;
        fork
            run_rand(0, 300);
            run_rand(1, 1000);
            run_rand(2, 1000);
            run_rand(3, 1000);
        join

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got time limit expected completion");
        $fatal(1);
    end

endmodule
